// File: rtl/tub_pkg.sv
// Shared constants and types for the tube display path.
// The upstream difference/abs-value stage uses the same segment codes.
package tub_pkg;

    localparam logic [7:0] SEG_BLANK      = 8'h00;
    localparam int         DEF_NUM_DIGITS = 8;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    // Segment byte layout: bit7..0 = a,b,c,d,e,f,g,dp, active-high.
    localparam logic [7:0] SEG_MINUS = 8'h02;
    localparam logic [7:0] SEG_DP    = 8'h01;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // A single-digit array still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tub_scan_prescaler.sv
// Slot counter and digit index for the tube scan; both freeze while disabled.
// Exports the frame boundary strobes used for snapshot and frame_done.
module tub_scan_prescaler
    import tub_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIV_CNT    = 100000,
    parameter int CNT_W      = $clog2(DIV_CNT),
    parameter int IDX_W      = idx_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_start_o,
    output logic             frame_end_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cnt_wrap;
    logic             idx_wrap;

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign idx_wrap = (idx_q == IDX_MAX);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en_i) begin
            if (cnt_wrap) begin
                cnt_d = '0;
                idx_d = idx_wrap ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign idx_o         = idx_q;
    assign frame_start_o = (cnt_q == '0) && (idx_q == '0);
    assign frame_end_o   = cnt_wrap && idx_wrap;

endmodule

// File: rtl/tub_scan_driver.sv
// Multiplexes per-digit segment bytes onto a shared bus with one-hot selects.
// Inputs are snapshotted once per frame; each slot opens with a blanking gap.
module tub_scan_driver
    import tub_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIV_CNT    = 100000,
    parameter int BLANK_CYC  = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_en,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   tub_sel,
    output logic [7:0]              tub_control,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIV_CNT);
    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             frame_start;
    logic             frame_end;

    tub_scan_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV_CNT    (DIV_CNT),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_prescaler (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (scan_en),
        .cnt_o         (cnt),
        .idx_o         (idx),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    logic [NUM_DIGITS-1:0][7:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      en_q, en_d;
    logic                       snap;

    assign snap = scan_en && frame_start;
    assign seg_d = snap ? seg_in : seg_q;
    assign en_d  = snap ? digit_en : en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            en_q  <= '0;
        end else begin
            seg_q <= seg_d;
            en_q  <= en_d;
        end
    end

    phase_e phase;

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign phase = PH_SHOW;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
            assign phase = (cnt < BLANK_END) ? PH_BLANK : PH_SHOW;
        end
    endgenerate

    // Decode against the shadow next-state so a capture and the first shown
    // cycle can coincide when there is no blanking gap.
    logic [NUM_DIGITS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hit
            assign hit[gi] = (phase == PH_SHOW) && en_d[gi] && (idx == IDX_W'(gi));
        end
    endgenerate

    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [7:0]            ctrl_q, ctrl_d;
    logic                  done_q, done_d;

    always_comb begin
        sel_d  = '0;
        ctrl_d = SEG_BLANK;
        done_d = 1'b0;
        if (scan_en) begin
            sel_d  = hit;
            done_d = frame_end;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (hit[i]) begin
                    ctrl_d = ctrl_d | seg_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            ctrl_q <= SEG_BLANK;
            done_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            ctrl_q <= ctrl_d;
            done_q <= done_d;
        end
    end

    assign tub_sel     = sel_q;
    assign tub_control = ctrl_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_tub_scan_driver.sv
// Directed and randomised checks of tub_scan_driver against a cycle model.
// Instance A: 2 digits, 4-cycle slots, 1 blank cycle. Instance B: 8 digits, 3-cycle slots, no blank.
module tb_tub_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        scan_en_a;
    logic [15:0] seg_in_a;
    logic [1:0]  digit_en_a;
    logic [1:0]  tub_sel_a;
    logic [7:0]  tub_control_a;
    logic        frame_done_a;

    logic        scan_en_b;
    logic [63:0] seg_in_b;
    logic [7:0]  digit_en_b;
    logic [7:0]  tub_sel_b;
    logic [7:0]  tub_control_b;
    logic        frame_done_b;

    tub_scan_driver #(.NUM_DIGITS(2), .DIV_CNT(4), .BLANK_CYC(1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en_a),
        .seg_in      (seg_in_a),
        .digit_en    (digit_en_a),
        .tub_sel     (tub_sel_a),
        .tub_control (tub_control_a),
        .frame_done  (frame_done_a)
    );

    tub_scan_driver #(.NUM_DIGITS(8), .DIV_CNT(3), .BLANK_CYC(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en_b),
        .seg_in      (seg_in_b),
        .digit_en    (digit_en_b),
        .tub_sel     (tub_sel_b),
        .tub_control (tub_control_b),
        .frame_done  (frame_done_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] sel_a;
        logic [7:0] ctrl_a;
        logic       fd_a;
        logic [7:0] sel_b;
        logic [7:0] ctrl_b;
        logic       fd_b;
    } exp_t;

    exp_t sb[$];

    int          ma_cnt, ma_idx, mb_cnt, mb_idx;
    logic [15:0] ma_seg;
    logic [1:0]  ma_en;
    logic [63:0] mb_seg;
    logic [7:0]  mb_en;

    // Directed expectations for the basic frame plus the mid-frame change.
    logic [1:0] frm_sel[16]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2,
                                 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2};
    logic [7:0] frm_ctrl[16] = '{8'h00, 8'h06, 8'h06, 8'h06, 8'h00, 8'h3F, 8'h3F, 8'h3F,
                                 8'h00, 8'h5B, 8'h5B, 8'h5B, 8'h00, 8'h3F, 8'h3F, 8'h3F};
    logic [1:0] dis_sel[8]   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
    logic [7:0] dis_ctrl[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma_cnt = 0; ma_idx = 0; ma_seg = '0; ma_en = '0;
        mb_cnt = 0; mb_idx = 0; mb_seg = '0; mb_en = '0;
    endtask

    // Predict the next registered outputs from current inputs, clock once, compare.
    task automatic tick();
        exp_t e;
        e.sel_a = '0; e.ctrl_a = '0; e.fd_a = 1'b0;
        e.sel_b = '0; e.ctrl_b = '0; e.fd_b = 1'b0;
        if (scan_en_a) begin
            if (ma_cnt == 0 && ma_idx == 0) begin
                ma_seg = seg_in_a;
                ma_en  = digit_en_a;
            end
            if (ma_cnt >= 1 && ma_en[ma_idx]) begin
                e.sel_a  = 2'(2'b01 << ma_idx);
                e.ctrl_a = ma_seg[8*ma_idx +: 8];
            end
            e.fd_a = (ma_cnt == 3 && ma_idx == 1);
            ma_cnt++;
            if (ma_cnt == 4) begin
                ma_cnt = 0;
                ma_idx = (ma_idx + 1) % 2;
            end
        end
        if (scan_en_b) begin
            if (mb_cnt == 0 && mb_idx == 0) begin
                mb_seg = seg_in_b;
                mb_en  = digit_en_b;
            end
            if (mb_en[mb_idx]) begin
                e.sel_b  = 8'(8'h01 << mb_idx);
                e.ctrl_b = mb_seg[8*mb_idx +: 8];
            end
            e.fd_b = (mb_cnt == 2 && mb_idx == 7);
            mb_cnt++;
            if (mb_cnt == 3) begin
                mb_cnt = 0;
                mb_idx = (mb_idx + 1) % 8;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sel_a",    64'(tub_sel_a),     64'(e.sel_a));
        chk("ctrl_a",   64'(tub_control_a), 64'(e.ctrl_a));
        chk("fd_a",     64'(frame_done_a),  64'(e.fd_a));
        chk("sel_b",    64'(tub_sel_b),     64'(e.sel_b));
        chk("ctrl_b",   64'(tub_control_b), 64'(e.ctrl_b));
        chk("fd_b",     64'(frame_done_b),  64'(e.fd_b));
        chk("onehot_b", 64'($countones(tub_sel_b) <= 1), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        scan_en_a  = 1'b0; seg_in_a = '0; digit_en_a = '0;
        scan_en_b  = 1'b0; seg_in_b = '0; digit_en_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel_a",  64'(tub_sel_a),     64'd0);
        chk("reset_ctrl_a", 64'(tub_control_a), 64'd0);
        chk("reset_fd_a",   64'(frame_done_a),  64'd0);
        chk("reset_sel_b",  64'(tub_sel_b),     64'd0);

        // Basic frame, then a digit-0 change after cycle 3 that waits for the next frame.
        seg_in_a   = {8'h3F, 8'h06};
        digit_en_a = 2'b11;
        scan_en_a  = 1'b1;
        rst_n      = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) seg_in_a[7:0] = 8'h5B;
            tick();
            chk("frame_sel",  64'(tub_sel_a),     64'(frm_sel[k]));
            chk("frame_ctrl", 64'(tub_control_a), 64'(frm_ctrl[k]));
            chk("frame_done", 64'(frame_done_a),  64'((k == 7) || (k == 15)));
        end

        // Disabled digit 0 still occupies its slot.
        digit_en_a    = 2'b10;
        seg_in_a[7:0] = 8'h06;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("dis_sel",  64'(tub_sel_a),     64'(dis_sel[k]));
            chk("dis_ctrl", 64'(tub_control_a), 64'(dis_ctrl[k]));
            chk("dis_done", 64'(frame_done_a),  64'(k == 7));
        end

        // Freeze mid-slot: hold cnt=2, then resume without a new snapshot.
        digit_en_a = 2'b11;
        repeat (8) tick();
        tick();
        tick();
        chk("pre_freeze_ctrl", 64'(tub_control_a), 64'h06);
        scan_en_a     = 1'b0;
        seg_in_a[7:0] = 8'h5B;
        repeat (5) begin
            tick();
            chk("freeze_sel",  64'(tub_sel_a),     64'd0);
            chk("freeze_ctrl", 64'(tub_control_a), 64'd0);
        end
        scan_en_a = 1'b1;
        tick();
        chk("resume_ctrl0", 64'(tub_control_a), 64'h06);
        chk("resume_sel0",  64'(tub_sel_a),     64'd1);
        tick();
        chk("resume_ctrl1", 64'(tub_control_a), 64'h06);
        tick();
        chk("resume_blank", 64'(tub_sel_a),     64'd0);
        repeat (3) tick();
        tick();
        tick();
        chk("resume_newframe", 64'(tub_control_a), 64'h5B);

        // Asynchronous reset while digit 0 is lit.
        repeat (6) tick();
        tick();
        tick();
        chk("prereset_sel", 64'(tub_sel_a), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel",  64'(tub_sel_a),     64'd0);
        chk("async_rst_ctrl", 64'(tub_control_a), 64'd0);
        chk("async_rst_fd",   64'(frame_done_a),  64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_sel", 64'(tub_sel_a), 64'd1);

        // Randomised scan on the 8-digit instance.
        scan_en_a = 1'b0;
        scan_en_b = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            seg_in_b   = {$urandom, $urandom};
            digit_en_b = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
